uart_link_buffered: RTL and testbench

//  Parametrised UART link: TX FIFO feeding a serialiser, oversampled RX deserialiser, optional internal loopback.

---
 rtl/uart_link_buffered.sv | 375 +++++++++++++++++++++++++++++++++++++
 tb/tb_uart_link_buffered.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_link_buffered.sv
// uart_link_buffered: TX FIFO feeding a serialiser, oversampled RX deserialiser, internal loopback and self-check.
// Define PARITY_EN to add an even parity bit to every frame in both directions.
module uart_link_buffered #(
  parameter int CLKS_PER_BIT = 5208,
  parameter int DATA_BITS    = 8,
  parameter int FIFO_DEPTH   = 4,
  parameter int STOP_BITS    = 1
) (
  input  logic                 i_Clock,
  input  logic                 i_Reset,
  input  logic                 i_Tx_DV,
  input  logic [DATA_BITS-1:0] i_Tx_Byte,
  output logic                 o_Tx_Ready,
  output logic                 o_Tx_Active,
  output logic                 o_Tx_Serial,
  input  logic                 i_Rx_Serial,
  input  logic                 i_Loopback,
  output logic                 o_Rx_DV,
  output logic [DATA_BITS-1:0] o_Rx_Byte,
  output logic                 o_Frame_Err,
  output logic                 o_Parity_Err,
  output logic                 o_Overflow,
  output logic [7:0]           o_Err_Count
);

  localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNTF_W = PTR_W + 1;
  localparam int CNT_W  = $clog2(CLKS_PER_BIT * STOP_BITS + 1);
  localparam logic [CNTF_W-1:0] FIFO_FULL = CNTF_W'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0]  BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0]  HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0]  STOP_LAST = CNT_W'(CLKS_PER_BIT * STOP_BITS - 1);
  localparam logic [3:0]        DBIT_LAST = 4'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    TX_IDLE = 3'd0, TX_START = 3'd1, TX_DATA = 3'd2, TX_PARITY = 3'd3, TX_STOP = 3'd4
  } tx_state_t;

  typedef enum logic [2:0] {
    RX_IDLE = 3'd0, RX_START = 3'd1, RX_DATA = 3'd2, RX_PARITY = 3'd3, RX_STOP = 3'd4,
    RX_CLEANUP = 3'd5
  } rx_state_t;

`ifdef PARITY_EN
  function automatic logic even_parity(input logic [DATA_BITS-1:0] word);
    return ^word;
  endfunction
`endif

  // FIFO storage and bookkeeping
  logic [DATA_BITS-1:0] fifo_mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNTF_W-1:0]    count_q, count_d;
  logic                 tx_ready_q, tx_ready_d, overflow_q, overflow_d;
  logic                 wr_en_s, rd_en_s, fifo_empty_s;
  logic [DATA_BITS-1:0] fifo_head_s;

  // Serialiser state
  tx_state_t            tx_state_q, tx_state_d;
  logic [CNT_W-1:0]     tx_cnt_q, tx_cnt_d;
  logic [3:0]           tx_bit_q, tx_bit_d;
  logic [DATA_BITS-1:0] tx_shift_q, tx_shift_d, last_sent_q, last_sent_d;
  logic                 tx_line_q, tx_line_d, tx_out_q, tx_out_d, tx_active_q, tx_active_d;

  // Deserialiser state
  rx_state_t            rx_state_q, rx_state_d;
  logic                 rx_in_s, rx_meta_q, rx_sync_q;
  logic [CNT_W-1:0]     rx_cnt_q, rx_cnt_d;
  logic [3:0]           rx_bit_q, rx_bit_d;
  logic [DATA_BITS-1:0] rx_shift_q, rx_shift_d, rx_byte_q, rx_byte_d, rx_ref_q, rx_ref_d;
  logic                 rx_perr_q, rx_perr_d;
  logic                 rx_dv_q, rx_dv_d, frame_err_q, frame_err_d, par_err_q, par_err_d;
  logic [7:0]           err_count_q, err_count_d;

  assign wr_en_s      = i_Tx_DV && tx_ready_q;
  assign fifo_empty_s = (count_q == {CNTF_W{1'b0}});
  assign fifo_head_s  = fifo_mem_q[rd_ptr_q];
  assign rx_in_s      = i_Loopback ? tx_line_q : i_Rx_Serial;

  // FIFO pointer, occupancy, ready and overflow next-state
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_en_s) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (rd_en_s) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({wr_en_s, rd_en_s})
      2'b10:   count_d = count_q + CNTF_W'(1);
      2'b01:   count_d = count_q - CNTF_W'(1);
      default: count_d = count_q;
    endcase
    tx_ready_d = (count_d != FIFO_FULL);
    overflow_d = overflow_q || (i_Tx_DV && !tx_ready_q);
  end

  // FIFO registers; reset discards any queued words
  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      wr_ptr_q   <= {PTR_W{1'b0}};
      rd_ptr_q   <= {PTR_W{1'b0}};
      count_q    <= {CNTF_W{1'b0}};
      tx_ready_q <= 1'b1;
      overflow_q <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) fifo_mem_q[i] <= {DATA_BITS{1'b0}};
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      tx_ready_q <= tx_ready_d;
      overflow_q <= overflow_d;
      if (wr_en_s) fifo_mem_q[wr_ptr_q] <= i_Tx_Byte;
    end
  end

  // TX next-state; popping straight out of STOP keeps back-to-back frames gapless
  always_comb begin
    tx_state_d  = tx_state_q;
    tx_cnt_d    = tx_cnt_q;
    tx_bit_d    = tx_bit_q;
    tx_shift_d  = tx_shift_q;
    last_sent_d = last_sent_q;
    tx_line_d   = 1'b1;
    rd_en_s     = 1'b0;
    case (tx_state_q)
      TX_IDLE: begin
        if (!fifo_empty_s) begin
          rd_en_s     = 1'b1;
          tx_state_d  = TX_START;
          tx_cnt_d    = {CNT_W{1'b0}};
          tx_shift_d  = fifo_head_s;
          last_sent_d = fifo_head_s;
        end else begin
          tx_state_d = TX_IDLE;
        end
      end
      TX_START: begin
        tx_line_d = 1'b0;
        if (tx_cnt_q == BIT_LAST) begin
          tx_state_d = TX_DATA;
          tx_cnt_d   = {CNT_W{1'b0}};
          tx_bit_d   = 4'd0;
        end else begin
          tx_cnt_d = tx_cnt_q + CNT_W'(1);
        end
      end
      TX_DATA: begin
        tx_line_d = tx_shift_q[0];
        if (tx_cnt_q == BIT_LAST) begin
          tx_cnt_d   = {CNT_W{1'b0}};
          tx_shift_d = {1'b0, tx_shift_q[DATA_BITS-1:1]};
          if (tx_bit_q == DBIT_LAST) begin
`ifdef PARITY_EN
            tx_state_d = TX_PARITY;
`else
            tx_state_d = TX_STOP;
`endif
          end else begin
            tx_bit_d = tx_bit_q + 4'd1;
          end
        end else begin
          tx_cnt_d = tx_cnt_q + CNT_W'(1);
        end
      end
      TX_PARITY: begin
`ifdef PARITY_EN
        tx_line_d = even_parity(last_sent_q);
`else
        tx_line_d = 1'b1;
`endif
        if (tx_cnt_q == BIT_LAST) begin
          tx_state_d = TX_STOP;
          tx_cnt_d   = {CNT_W{1'b0}};
        end else begin
          tx_cnt_d = tx_cnt_q + CNT_W'(1);
        end
      end
      TX_STOP: begin
        tx_line_d = 1'b1;
        if (tx_cnt_q == STOP_LAST) begin
          tx_cnt_d = {CNT_W{1'b0}};
          if (!fifo_empty_s) begin
            rd_en_s     = 1'b1;
            tx_state_d  = TX_START;
            tx_shift_d  = fifo_head_s;
            last_sent_d = fifo_head_s;
          end else begin
            tx_state_d = TX_IDLE;
          end
        end else begin
          tx_cnt_d = tx_cnt_q + CNT_W'(1);
        end
      end
      default: begin
        tx_state_d = TX_IDLE;
        tx_line_d  = 1'b1;
      end
    endcase
    tx_out_d    = i_Loopback ? 1'b1 : tx_line_d;
    tx_active_d = (tx_state_d != TX_IDLE);
  end

  // TX registers; the line forces high on reset
  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      tx_state_q  <= TX_IDLE;
      tx_cnt_q    <= {CNT_W{1'b0}};
      tx_bit_q    <= 4'd0;
      tx_shift_q  <= {DATA_BITS{1'b0}};
      last_sent_q <= {DATA_BITS{1'b0}};
      tx_line_q   <= 1'b1;
      tx_out_q    <= 1'b1;
      tx_active_q <= 1'b0;
    end else begin
      tx_state_q  <= tx_state_d;
      tx_cnt_q    <= tx_cnt_d;
      tx_bit_q    <= tx_bit_d;
      tx_shift_q  <= tx_shift_d;
      last_sent_q <= last_sent_d;
      tx_line_q   <= tx_line_d;
      tx_out_q    <= tx_out_d;
      tx_active_q <= tx_active_d;
    end
  end

  // RX next-state and self-check; rx_ref captures last_sent at start detection because
  // the RX stop sample can land after TX has already popped the following word
  always_comb begin
    rx_state_d  = rx_state_q;
    rx_cnt_d    = rx_cnt_q;
    rx_bit_d    = rx_bit_q;
    rx_shift_d  = rx_shift_q;
    rx_byte_d   = rx_byte_q;
    rx_ref_d    = rx_ref_q;
    rx_perr_d   = rx_perr_q;
    rx_dv_d     = 1'b0;
    frame_err_d = 1'b0;
    par_err_d   = 1'b0;
    case (rx_state_q)
      RX_IDLE: begin
        if (!rx_sync_q) begin
          rx_state_d = RX_START;
          rx_cnt_d   = {CNT_W{1'b0}};
          rx_perr_d  = 1'b0;
          rx_ref_d   = last_sent_q;
        end else begin
          rx_state_d = RX_IDLE;
        end
      end
      RX_START: begin
        if (rx_cnt_q == HALF_LAST) begin
          rx_cnt_d = {CNT_W{1'b0}};
          rx_bit_d = 4'd0;
          if (!rx_sync_q) begin
            rx_state_d = RX_DATA;
          end else begin
            rx_state_d = RX_IDLE;
          end
        end else begin
          rx_cnt_d = rx_cnt_q + CNT_W'(1);
        end
      end
      RX_DATA: begin
        if (rx_cnt_q == BIT_LAST) begin
          rx_cnt_d   = {CNT_W{1'b0}};
          rx_shift_d = {rx_sync_q, rx_shift_q[DATA_BITS-1:1]};
          if (rx_bit_q == DBIT_LAST) begin
`ifdef PARITY_EN
            rx_state_d = RX_PARITY;
`else
            rx_state_d = RX_STOP;
`endif
          end else begin
            rx_bit_d = rx_bit_q + 4'd1;
          end
        end else begin
          rx_cnt_d = rx_cnt_q + CNT_W'(1);
        end
      end
      RX_PARITY: begin
        if (rx_cnt_q == BIT_LAST) begin
          rx_cnt_d   = {CNT_W{1'b0}};
          rx_state_d = RX_STOP;
`ifdef PARITY_EN
          rx_perr_d  = (rx_sync_q != even_parity(rx_shift_q));
`else
          rx_perr_d  = 1'b0;
`endif
        end else begin
          rx_cnt_d = rx_cnt_q + CNT_W'(1);
        end
      end
      RX_STOP: begin
        if (rx_cnt_q == BIT_LAST) begin
          rx_cnt_d    = {CNT_W{1'b0}};
          rx_state_d  = RX_CLEANUP;
          frame_err_d = !rx_sync_q;
          par_err_d   = rx_perr_q;
          if (rx_sync_q && !rx_perr_q) begin
            rx_dv_d   = 1'b1;
            rx_byte_d = rx_shift_q;
          end else begin
            rx_dv_d = 1'b0;
          end
        end else begin
          rx_cnt_d = rx_cnt_q + CNT_W'(1);
        end
      end
      RX_CLEANUP: begin
        if (rx_sync_q) begin
          rx_state_d = RX_IDLE;
        end else begin
          rx_state_d = RX_CLEANUP;
        end
      end
      default: rx_state_d = RX_IDLE;
    endcase
    if (rx_dv_q && i_Loopback && (rx_byte_q != rx_ref_q) && (err_count_q != 8'hFF)) begin
      err_count_d = err_count_q + 8'd1;
    end else begin
      err_count_d = err_count_q;
    end
  end

  // RX synchroniser, FSM and output pulse registers
  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      rx_meta_q   <= 1'b1;
      rx_sync_q   <= 1'b1;
      rx_state_q  <= RX_IDLE;
      rx_cnt_q    <= {CNT_W{1'b0}};
      rx_bit_q    <= 4'd0;
      rx_shift_q  <= {DATA_BITS{1'b0}};
      rx_byte_q   <= {DATA_BITS{1'b0}};
      rx_ref_q    <= {DATA_BITS{1'b0}};
      rx_perr_q   <= 1'b0;
      rx_dv_q     <= 1'b0;
      frame_err_q <= 1'b0;
      par_err_q   <= 1'b0;
      err_count_q <= 8'd0;
    end else begin
      rx_meta_q   <= rx_in_s;
      rx_sync_q   <= rx_meta_q;
      rx_state_q  <= rx_state_d;
      rx_cnt_q    <= rx_cnt_d;
      rx_bit_q    <= rx_bit_d;
      rx_shift_q  <= rx_shift_d;
      rx_byte_q   <= rx_byte_d;
      rx_ref_q    <= rx_ref_d;
      rx_perr_q   <= rx_perr_d;
      rx_dv_q     <= rx_dv_d;
      frame_err_q <= frame_err_d;
      par_err_q   <= par_err_d;
      err_count_q <= err_count_d;
    end
  end

  assign o_Tx_Ready   = tx_ready_q;
  assign o_Tx_Active  = tx_active_q;
  assign o_Tx_Serial  = tx_out_q;
  assign o_Rx_DV      = rx_dv_q;
  assign o_Rx_Byte    = rx_byte_q;
  assign o_Frame_Err  = frame_err_q;
  assign o_Parity_Err = par_err_q;
  assign o_Overflow   = overflow_q;
  assign o_Err_Count  = err_count_q;

endmodule

// File: tb/tb_uart_link_buffered.sv
// Directed/randomised bench for uart_link_buffered with a queue-based reference model.
module tb_uart_link_buffered;

  localparam int CPB = 4;
  localparam int DW  = 8;
`ifdef PARITY_EN
  localparam int PBITS = 1;
`else
  localparam int PBITS = 0;
`endif
  localparam int FRAME_BITS = 1 + DW + PBITS + 1;
  localparam int FRAME_CYC  = FRAME_BITS * CPB;

  typedef bit bitq_t[$];

  logic          clk = 1'b0;
  logic          rst;
  logic          i_Tx_DV;
  logic [DW-1:0] i_Tx_Byte;
  logic          o_Tx_Ready, o_Tx_Active, o_Tx_Serial;
  logic          i_Rx_Serial, i_Loopback;
  logic          o_Rx_DV;
  logic [DW-1:0] o_Rx_Byte;
  logic          o_Frame_Err, o_Parity_Err, o_Overflow;
  logic [7:0]    o_Err_Count;

  int tests_run = 0;
  int tests_failed = 0;
  int cyc = 0;

  int         ev_dv, ev_fe, ev_pe;
  bit         ev_txlow;
  logic [7:0] ev_bytes[$];
  int         ev_stamp[$];

  always #5 clk = ~clk;

  uart_link_buffered #(
    .CLKS_PER_BIT(CPB), .DATA_BITS(DW), .FIFO_DEPTH(4), .STOP_BITS(1)
  ) dut (
    .i_Clock(clk), .i_Reset(rst),
    .i_Tx_DV(i_Tx_DV), .i_Tx_Byte(i_Tx_Byte),
    .o_Tx_Ready(o_Tx_Ready), .o_Tx_Active(o_Tx_Active), .o_Tx_Serial(o_Tx_Serial),
    .i_Rx_Serial(i_Rx_Serial), .i_Loopback(i_Loopback),
    .o_Rx_DV(o_Rx_DV), .o_Rx_Byte(o_Rx_Byte),
    .o_Frame_Err(o_Frame_Err), .o_Parity_Err(o_Parity_Err),
    .o_Overflow(o_Overflow), .o_Err_Count(o_Err_Count)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic sample();
    if (o_Rx_DV === 1'b1) begin
      ev_dv++;
      ev_bytes.push_back(o_Rx_Byte);
      ev_stamp.push_back(cyc);
    end
    if (o_Frame_Err === 1'b1) ev_fe++;
    if (o_Parity_Err === 1'b1) ev_pe++;
    if (o_Tx_Serial !== 1'b1) ev_txlow = 1'b1;
  endtask

  task automatic clear_ev();
    ev_dv = 0; ev_fe = 0; ev_pe = 0; ev_txlow = 1'b0;
    ev_bytes.delete();
    ev_stamp.delete();
  endtask

  task automatic tick();
    @(negedge clk);
    cyc++;
    sample();
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic write_word(input logic [7:0] w);
    i_Tx_DV = 1'b1; i_Tx_Byte = w;
    tick();
    i_Tx_DV = 1'b0;
  endtask

  // Reference frame: start 0, data LSB first, optional even parity, stop
  function automatic bitq_t make_frame(input logic [7:0] w, input bit stop_v);
    bitq_t q;
    q.push_back(1'b0);
    for (int i = 0; i < DW; i++) q.push_back(w[i]);
`ifdef PARITY_EN
    q.push_back(^w);
`endif
    q.push_back(stop_v);
    return q;
  endfunction

  task automatic drive_bits(input bitq_t q);
    foreach (q[i]) begin
      i_Rx_Serial = q[i];
      repeat (CPB) tick();
    end
    i_Rx_Serial = 1'b1;
    repeat (3 * CPB) tick();
  endtask

  task automatic check_reset_outputs(input string pfx);
    check({pfx, "_tx_serial"}, o_Tx_Serial, 1);
    check({pfx, "_tx_ready"}, o_Tx_Ready, 1);
    check({pfx, "_tx_active"}, o_Tx_Active, 0);
    check({pfx, "_rx_dv"}, o_Rx_DV, 0);
    check({pfx, "_rx_byte"}, o_Rx_Byte, 0);
    check({pfx, "_frame_err"}, o_Frame_Err, 0);
    check({pfx, "_parity_err"}, o_Parity_Err, 0);
    check({pfx, "_overflow"}, o_Overflow, 0);
    check({pfx, "_err_count"}, o_Err_Count, 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] w, w0;
    logic [7:0] exp_q[$];
    int err_model;
    int waited;
    bitq_t fr;

    rst = 1'b1; i_Tx_DV = 1'b0; i_Tx_Byte = 8'h00; i_Rx_Serial = 1'b1; i_Loopback = 1'b1;
    clear_ev();
    idle(3);
    check_reset_outputs("rst");
    rst = 1'b0;
    idle(3);

    // Single loopback words: one DV each, line held high, no self-check errors
    for (int k = 0; k < 4; k++) begin
      w = (k == 0) ? 8'hA5 : 8'($urandom);
      clear_ev();
      check("a_ready", o_Tx_Ready, 1);
      write_word(w);
      idle(FRAME_CYC + 20);
      check("a_dv_count", ev_dv, 1);
      if (ev_bytes.size() > 0) check("a_dv_byte", ev_bytes[0], w);
      check("a_rx_byte", o_Rx_Byte, w);
      check("a_tx_low", ev_txlow, 0);
      check("a_err_count", o_Err_Count, 0);
    end

    // Five consecutive writes from empty: all accepted, in order, frames abut
    clear_ev();
    for (int k = 1; k <= 5; k++) begin
      check("b_ready", o_Tx_Ready, 1);
      i_Tx_DV = 1'b1; i_Tx_Byte = 8'(k);
      tick();
    end
    i_Tx_DV = 1'b0;
    idle(5 * FRAME_CYC + 30);
    check("b_dv_count", ev_dv, 5);
    for (int i = 0; i < ev_bytes.size() && i < 5; i++) check("b_order", ev_bytes[i], i + 1);
    for (int i = 1; i < ev_stamp.size() && i < 5; i++)
      check("b_gap", ev_stamp[i] - ev_stamp[i-1], FRAME_CYC);
    check("b_tx_low", ev_txlow, 0);
    check("b_err_count", o_Err_Count, 0);

    // Overflow: five writes fill the FIFO behind a busy TX, 0x77 is dropped
    clear_ev();
    exp_q.delete();
    for (int k = 0; k < 5; k++) begin
      w = 8'($urandom_range(0, 118));
      exp_q.push_back(w);
      i_Tx_DV = 1'b1; i_Tx_Byte = w;
      tick();
    end
    check("c_ready_full", o_Tx_Ready, 0);
    check("c_overflow_pre", o_Overflow, 0);
    i_Tx_DV = 1'b1; i_Tx_Byte = 8'h77;
    tick();
    i_Tx_DV = 1'b0;
    tick();
    check("c_overflow_set", o_Overflow, 1);
    idle(6 * FRAME_CYC);
    check("c_dv_count", ev_dv, 5);
    for (int i = 0; i < ev_bytes.size() && i < 5; i++) check("c_order", ev_bytes[i], exp_q[i]);
    check("c_overflow_sticky", o_Overflow, 1);
    check("c_ready_back", o_Tx_Ready, 1);

    // External RX: valid frame, stop=0 frame, 1-cycle glitch, more valid frames
    i_Loopback = 1'b0;
    idle(4);
    clear_ev();
    w0 = 8'($urandom);
    drive_bits(make_frame(w0, 1'b1));
    check("d_valid_dv", ev_dv, 1);
    check("d_valid_byte", o_Rx_Byte, w0);
    check("d_valid_fe", ev_fe, 0);

    clear_ev();
    drive_bits(make_frame(8'h3C, 1'b0));
    check("d_stop0_fe", ev_fe, 1);
    check("d_stop0_dv", ev_dv, 0);
    check("d_stop0_byte", o_Rx_Byte, w0);

    clear_ev();
    i_Rx_Serial = 1'b0;
    tick();
    i_Rx_Serial = 1'b1;
    idle(FRAME_CYC);
    check("d_glitch_dv", ev_dv, 0);
    check("d_glitch_fe", ev_fe, 0);
    check("d_glitch_pe", ev_pe, 0);
    check("d_glitch_byte", o_Rx_Byte, w0);

    for (int k = 0; k < 4; k++) begin
      clear_ev();
      w = 8'($urandom);
      drive_bits(make_frame(w, 1'b1));
      check("d_rand_dv", ev_dv, 1);
      check("d_rand_byte", o_Rx_Byte, w);
      check("d_rand_pe", ev_pe, 0);
    end

`ifdef PARITY_EN
    // Odd parity on 0x3C: parity error pulse, no DV
    clear_ev();
    w0 = o_Rx_Byte;
    fr = make_frame(8'h3C, 1'b1);
    fr[DW+1] = ~fr[DW+1];
    drive_bits(fr);
    check("e_parity_pe", ev_pe, 1);
    check("e_parity_dv", ev_dv, 0);
    check("e_parity_fe", ev_fe, 0);
    check("e_parity_byte", o_Rx_Byte, w0);
`endif

    // Self-check: corrupt data bit 0 by steering RX to a high external line during that bit
    i_Loopback = 1'b1;
    i_Rx_Serial = 1'b1;
    idle(5);
    err_model = 0;
    for (int f = 0; f < 300; f++) begin
      w = 8'($urandom) & 8'hFE;
      clear_ev();
      write_word(w);
      idle(6);
      i_Loopback = 1'b0;
      idle(4);
      i_Loopback = 1'b1;
      waited = 0;
      while (ev_dv == 0 && waited < 100) begin
        tick();
        waited++;
      end
      check("f_dv_seen", ev_dv, 1);
      if (ev_bytes.size() > 0) check("f_corrupt_byte", ev_bytes[0], w | 8'h01);
      idle(4);
      err_model = (err_model < 255) ? err_model + 1 : 255;
      check("f_err_count", o_Err_Count, err_model);
    end
    check("f_err_final", o_Err_Count, 255);

    // Async reset in the middle of a frame
    w = 8'($urandom);
    write_word(w);
    idle(15);
    check("g_active_midframe", o_Tx_Active, 1);
    #2 rst = 1'b1;
    #1 check_reset_outputs("g_async");
    tick();
    tick();
    rst = 1'b0;
    clear_ev();
    idle(FRAME_CYC + 20);
    check("g_post_dv", ev_dv, 0);
    check("g_post_active", o_Tx_Active, 0);
    check("g_post_ready", o_Tx_Ready, 1);
    check("g_post_err", o_Err_Count, 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
